// File: rtl/dmix_lrck_rate_detect.sv
// LR clock rate detector: measures the frame period in master-clock cycles,
// classifies it as 48/96/192 kHz and reports a locked rate to the mixer core.
module dmix_lrck_rate_detect #(
    parameter int PERIOD_W    = 12,
    parameter int TOL         = 16,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                clk983040,
    input  logic                rst,
    input  logic                lrck_pad,
    output logic [1:0]          rate,
    output logic                locked,
    output logic [PERIOD_W-1:0] period,
    output logic                rate_change
);

    localparam int                  EXT_W    = PERIOD_W + 1;
    localparam int                  CONSEC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic [EXT_W-1:0]    TOL_X    = EXT_W'(TOL);
    localparam logic [EXT_W-1:0]    NOM_48   = EXT_W'(2048);
    localparam logic [EXT_W-1:0]    NOM_96   = EXT_W'(1024);
    localparam logic [EXT_W-1:0]    NOM_192  = EXT_W'(512);
    localparam logic [CONSEC_W-1:0] LOCK_CNT = CONSEC_W'(LOCK_FRAMES);
    localparam logic [CONSEC_W-1:0] CONSEC_1 = CONSEC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_TRACK,
        S_LOCKED
    } state_t;

    state_t              state, state_n;
    logic                sync1, sync2, sync3;
    logic                rise;
    logic [PERIOD_W-1:0] cnt;
    logic                cnt_sat;
    logic [EXT_W-1:0]    m_x;
    logic [1:0]          cls;
    logic [1:0]          cand, cand_n;
    logic [CONSEC_W-1:0] consec, consec_n, consec_inc;
    logic [1:0]          rate_n;
    logic                locked_n;
    logic [PERIOD_W-1:0] period_n;
    logic                rate_change_n;

    // lrck_pad is asynchronous: two flops to resolve metastability, a third for the edge.
    always_ff @(posedge clk983040) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= lrck_pad;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise    = sync2 & ~sync3;
    assign cnt_sat = (cnt == CNT_MAX);

    always_ff @(posedge clk983040) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (!cnt_sat) begin
            cnt <= cnt + 1'b1;
        end
    end

    // One extra bit of headroom so m + TOL cannot wrap near saturation.
    function automatic logic near(input logic [EXT_W-1:0] m, input logic [EXT_W-1:0] nom);
        return ((m + TOL_X) >= nom) && (m <= (nom + TOL_X));
    endfunction

    assign m_x = {1'b0, cnt};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cls = 2'd0;
        if (near(m_x, NOM_48)) begin
            cls = 2'd1;
        end else if (near(m_x, NOM_96)) begin
            cls = 2'd2;
        end else if (near(m_x, NOM_192)) begin
            cls = 2'd3;
        end
    end

    assign consec_inc = consec + 1'b1;

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        consec_n = consec;
        rate_n   = rate;
        locked_n = locked;
        period_n = period;
        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (rise) begin
                    period_n = cnt;
                    if (cls != 2'd0) begin
                        state_n  = S_TRACK;
                        cand_n   = cls;
                        consec_n = CONSEC_1;
                    end
                end else if (cnt_sat) begin
                    state_n = S_IDLE;
                end
            end
            S_TRACK: begin
                if (rise) begin
                    period_n = cnt;
                    if (cls == cand) begin
                        consec_n = consec_inc;
                        if (consec_inc == LOCK_CNT) begin
                            state_n  = S_LOCKED;
                            locked_n = 1'b1;
                            rate_n   = cand;
                        end
                    end else if (cls != 2'd0) begin
                        cand_n   = cls;
                        consec_n = CONSEC_1;
                    end else begin
                        state_n = S_MEASURE;
                    end
                end else if (cnt_sat) begin
                    state_n = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (rise) begin
                    period_n = cnt;
                    if (cls != rate) begin
                        locked_n = 1'b0;
                        rate_n   = 2'd0;
                        if (cls != 2'd0) begin
                            state_n  = S_TRACK;
                            cand_n   = cls;
                            consec_n = CONSEC_1;
                        end else begin
                            state_n = S_MEASURE;
                        end
                    end
                end else if (cnt_sat) begin
                    state_n  = S_IDLE;
                    locked_n = 1'b0;
                    rate_n   = 2'd0;
                end
            end
        endcase
        rate_change_n = (locked_n != locked) || (rate_n != rate);
    end

    always_ff @(posedge clk983040) begin
        if (rst) begin
            state       <= S_IDLE;
            cand        <= 2'd0;
            consec      <= '0;
            rate        <= 2'd0;
            locked      <= 1'b0;
            period      <= '0;
            rate_change <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            consec      <= consec_n;
            rate        <= rate_n;
            locked      <= locked_n;
            period      <= period_n;
            rate_change <= rate_change_n;
        end
    end

endmodule

// File: tb/tb_dmix_lrck_rate_detect.sv
// Bench for dmix_lrck_rate_detect: directed vector table, timeout/glitch/reset
// sequences and randomized periods against a frame-history reference model.
module tb_dmix_lrck_rate_detect;

    localparam int PERIOD_W    = 12;
    localparam int TOL         = 16;
    localparam int LOCK_FRAMES = 4;
    localparam int NV          = 23;

    logic                clk983040 = 1'b0;
    logic                rst       = 1'b1;
    logic                lrck_pad  = 1'b0;
    logic [1:0]          rate;
    logic                locked;
    logic [PERIOD_W-1:0] period;
    logic                rate_change;

    dmix_lrck_rate_detect #(
        .PERIOD_W   (PERIOD_W),
        .TOL        (TOL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk983040  (clk983040),
        .rst        (rst),
        .lrck_pad   (lrck_pad),
        .rate       (rate),
        .locked     (locked),
        .period     (period),
        .rate_change(rate_change)
    );

    always #5 clk983040 = ~clk983040;

    typedef struct {
        int len;
        int hi;
        int e_locked;
        int e_rate;
        int e_period;
        int e_pulse;
    } vec_t;

    vec_t tbl [NV];
    vec_t tv_cur;
    bit   tv_valid = 1'b0;

    int n_cmp       = 0;
    int n_bad       = 0;
    int n_rise      = 0;
    int pulses      = 0;
    int pulses_base = 0;
    int prev_len    = 0;

    // Reference model: classes of every measured period since leaving idle.
    bit m_idle   = 1'b1;
    int m_period = 0;
    int m_locked = 0;
    int m_rate   = 0;
    int m_hist [$];

    always @(negedge clk983040) begin
        if (rate_change === 1'b1) pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (rise %0d): got %0d, expected %0d", name, n_rise, act, exp);
        end
    endtask

    function automatic int classify(input int m);
        int noms [3];
        noms[0] = 2048;
        noms[1] = 1024;
        noms[2] = 512;
        for (int k = 0; k < 3; k++) begin
            if (m >= noms[k] - TOL && m <= noms[k] + TOL) return k + 1;
        end
        return 0;
    endfunction

    task automatic model_rise(input int m, output int exp_pulse);
        int old_l;
        int old_r;
        int run;
        int last;
        old_l = m_locked;
        old_r = m_rate;
        if (m_idle) begin
            m_idle = 1'b0;
            m_hist.delete();
        end else begin
            m_period = (m > 4095) ? 4095 : m;
            m_hist.push_back(classify(m_period));
        end
        m_locked = 0;
        m_rate   = 0;
        if (m_hist.size() > 0 && m_hist[$] != 0) begin
            last = m_hist[$];
            run  = 0;
            for (int k = m_hist.size() - 1; k >= 0; k--) begin
                if (m_hist[k] != last) break;
                run++;
            end
            if (run >= LOCK_FRAMES) begin
                m_locked = 1;
                m_rate   = last;
            end
        end
        exp_pulse = (m_locked != old_l || m_rate != old_r) ? 1 : 0;
    endtask

    task automatic model_idle();
        m_idle   = 1'b1;
        m_locked = 0;
        m_rate   = 0;
        m_hist.delete();
    endtask

    task automatic do_rise_check();
        int ep;
        n_rise++;
        model_rise(prev_len, ep);
        check("rate",   {30'd0, rate},   m_rate);
        check("locked", {31'd0, locked}, m_locked);
        check("period", {20'd0, period}, m_period);
        check("pulse",  pulses - pulses_base, ep);
        if (tv_valid) begin
            check("tbl_rate",   {30'd0, rate},   tv_cur.e_rate);
            check("tbl_locked", {31'd0, locked}, tv_cur.e_locked);
            check("tbl_period", {20'd0, period}, tv_cur.e_period);
            check("tbl_pulse",  pulses - pulses_base, tv_cur.e_pulse);
        end
        pulses_base = pulses;
    endtask

    // One lrck frame starting with a rising edge; outputs for that edge are checked a few clocks in.
    task automatic drive_period(input int len, input int hi);
        for (int i = 0; i < len; i++) begin
            lrck_pad = (i < hi);
            @(negedge clk983040);
            if (i == 7) do_rise_check();
        end
        prev_len = len;
    endtask

    task automatic do_reset();
        int base;
        base = pulses;
        rst  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lrck_pad = i[0];
            @(negedge clk983040);
            if (i == 0) begin
                check("rst_rate",   {30'd0, rate},        0);
                check("rst_locked", {31'd0, locked},      0);
                check("rst_period", {20'd0, period},      0);
                check("rst_pulse",  {31'd0, rate_change}, 0);
            end
        end
        lrck_pad = 1'b0;
        rst      = 1'b0;
        repeat (10) @(negedge clk983040);
        check("post_rst_locked", {31'd0, locked}, 0);
        check("post_rst_period", {20'd0, period}, 0);
        check("rst_no_pulse",    pulses - base,   0);
        model_idle();
        m_period    = 0;
        pulses_base = pulses;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int nom;
        int len;
        int kind;
        int noms2 [2];

        tbl[0]  = '{2048, 1024, 0, 0, 0,    0};
        tbl[1]  = '{2048, 1024, 0, 0, 2048, 0};
        tbl[2]  = '{2048, 1024, 0, 0, 2048, 0};
        tbl[3]  = '{2048, 1024, 0, 0, 2048, 0};
        tbl[4]  = '{2048, 1024, 1, 1, 2048, 1};
        tbl[5]  = '{2048, 1024, 1, 1, 2048, 0};
        tbl[6]  = '{1040, 520,  1, 1, 2048, 0};
        tbl[7]  = '{1008, 504,  0, 0, 1040, 1};
        tbl[8]  = '{1040, 520,  0, 0, 1008, 0};
        tbl[9]  = '{1008, 504,  0, 0, 1040, 0};
        tbl[10] = '{1041, 520,  1, 2, 1008, 1};
        tbl[11] = '{1024, 512,  0, 0, 1041, 1};
        tbl[12] = '{1024, 512,  0, 0, 1024, 0};
        tbl[13] = '{512,  256,  0, 0, 1024, 0};
        tbl[14] = '{512,  256,  0, 0, 512,  0};
        tbl[15] = '{512,  256,  0, 0, 512,  0};
        tbl[16] = '{512,  256,  0, 0, 512,  0};
        tbl[17] = '{2048, 1024, 1, 3, 512,  1};
        tbl[18] = '{2048, 1024, 0, 0, 2048, 1};
        tbl[19] = '{2048, 1024, 0, 0, 2048, 0};
        tbl[20] = '{2048, 1024, 0, 0, 2048, 0};
        tbl[21] = '{2048, 1024, 1, 1, 2048, 1};
        tbl[22] = '{2048, 1024, 1, 1, 2048, 0};

        @(negedge clk983040);
        do_reset();

        // 48k lock, 96k tolerance edges, 192k lock and switch back to 48k.
        for (int k = 0; k < NV; k++) begin
            tv_cur   = tbl[k];
            tv_valid = 1'b1;
            drive_period(tbl[k].len, tbl[k].hi);
        end
        tv_valid = 1'b0;

        // Signal loss: lrck held low after the last rising edge.
        base = pulses;
        repeat (4000 - 2048) @(negedge clk983040);
        check("loss_pre_locked", {31'd0, locked}, 1);
        repeat (120) @(negedge clk983040);
        check("loss_locked", {31'd0, locked}, 0);
        check("loss_rate",   {30'd0, rate},   0);
        check("loss_period", {20'd0, period}, 2048);
        check("loss_pulse",  pulses - base,   1);
        model_idle();
        pulses_base = pulses;

        // Glitch: a 3-clock pulse in the low half of a locked 96k frame.
        repeat (6) drive_period(1024, 512);
        check("glitch_pre_locked", {31'd0, locked}, 1);
        drive_period(700, 512);
        drive_period(324, 3);
        check("glitch_drop", {31'd0, locked}, 0);
        repeat (5) drive_period(1024, 512);
        check("glitch_relock", {31'd0, locked}, 1);
        check("glitch_rate",   {30'd0, rate},   2);

        // Reset while locked: outputs clear with no rate_change pulse.
        do_reset();

        // Randomized periods around the 96k/192k nominals.
        noms2[0] = 1024;
        noms2[1] = 512;
        nom = noms2[$urandom_range(0, 1)];
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) nom = noms2[$urandom_range(0, 1)];
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                len = $urandom_range(400, 1500);
            end else if (kind == 1) begin
                len = ($urandom_range(0, 1) == 1) ? nom + TOL + 1 : nom - TOL - 1;
            end else if (kind == 2) begin
                len = ($urandom_range(0, 1) == 1) ? nom + TOL : nom - TOL;
            end else begin
                len = nom + $urandom_range(0, 2 * TOL) - TOL;
            end
            drive_period(len, $urandom_range(3, len - 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
